// File: rtl/delay_line_arbiter.sv
// Round-robin arbiter sharing one external fixed-latency delay line among P_REQS requesters.
// A shadow {valid, id} pipeline tracks slot ownership so returning words reach their owner.
module delay_line_arbiter #(
    parameter int P_REQS    = 4,
    parameter int P_DEPTH   = 8,
    parameter int P_WIDTH   = 8,
    parameter int P_MAX_OUT = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_flush,
    input  logic [P_REQS-1:0]           i_req,
    input  logic [P_REQS*P_WIDTH-1:0]   i_data,
    output logic [P_REQS-1:0]           o_gnt,
    output logic [P_WIDTH-1:0]          o_pipe_data,
    input  logic [P_WIDTH-1:0]          i_pipe_data,
    output logic [P_REQS-1:0]           o_rsp_vld,
    output logic [P_WIDTH-1:0]          o_rsp_data,
    output logic                        o_busy
);

    localparam int IDW   = (P_REQS > 1) ? $clog2(P_REQS) : 1;
    localparam int IDX_W = IDW + 1;
    localparam int CW    = $clog2(P_MAX_OUT + 1);
    localparam logic [CW-1:0]    MAX_C  = CW'(P_MAX_OUT);
    localparam logic [IDW-1:0]   LAST_ID = IDW'(P_REQS - 1);
    localparam logic [IDX_W-1:0] REQS_W = IDX_W'(P_REQS);

    logic [P_DEPTH-1:0] vld_q, vld_d;
    logic [IDW-1:0]     id_q [P_DEPTH];
    logic [IDW-1:0]     id_d [P_DEPTH];
    logic [CW-1:0]      cnt_q [P_REQS];
    logic [CW-1:0]      cnt_d [P_REQS];
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [P_WIDTH-1:0] pipe_q, pipe_d;

    logic [P_REQS-1:0]  elig;
    logic [P_REQS-1:0]  ret_hit;
    logic               ret_vld;
    logic [IDW-1:0]     ret_id;
    logic               gnt_any;
    logic [IDW-1:0]     gnt_idx;
    logic [IDX_W-1:0]   scan_sum;
    logic [IDW-1:0]     scan_cand;

    assign ret_vld = vld_q[P_DEPTH-1] & ~i_flush;
    assign ret_id  = id_q[P_DEPTH-1];

    // A requester at its limit may still be granted in the cycle one of its words returns.
    genvar gi;
    generate
        for (gi = 0; gi < P_REQS; gi++) begin : g_req
            assign ret_hit[gi] = ret_vld && (ret_id == IDW'(gi));
            assign elig[gi]    = i_rst && i_req[gi] && !i_flush &&
                                 ((cnt_q[gi] < MAX_C) || ret_hit[gi]);
        end
    endgenerate

    always_comb begin
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        scan_sum  = '0;
        scan_cand = '0;
        for (int i = 0; i < P_REQS; i++) begin
            scan_sum = {1'b0, ptr_q} + IDX_W'(i);
            if (scan_sum >= REQS_W) begin
                scan_sum = scan_sum - REQS_W;
            end
            scan_cand = scan_sum[IDW-1:0];
            if (!gnt_any && elig[scan_cand]) begin
                gnt_any = 1'b1;
                gnt_idx = scan_cand;
            end
        end
    end

    always_comb begin
        o_gnt = '0;
        if (gnt_any) begin
            o_gnt[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d  = ptr_q;
        pipe_d = pipe_q;
        if (gnt_any) begin
            ptr_d  = (gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1;
            pipe_d = i_data[gnt_idx*P_WIDTH +: P_WIDTH];
        end
    end

    always_comb begin
        vld_d    = '0;
        vld_d[0] = gnt_any & ~i_flush;
        id_d[0]  = gnt_idx;
        for (int s = 1; s < P_DEPTH; s++) begin
            vld_d[s] = vld_q[s-1] & ~i_flush;
            id_d[s]  = id_q[s-1];
        end
    end

    always_comb begin
        for (int k = 0; k < P_REQS; k++) begin
            cnt_d[k] = cnt_q[k];
            if (i_flush) begin
                cnt_d[k] = '0;
            end else if (o_gnt[k] && !ret_hit[k]) begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end else if (!o_gnt[k] && ret_hit[k]) begin
                cnt_d[k] = cnt_q[k] - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            vld_q  <= '0;
            ptr_q  <= '0;
            pipe_q <= '0;
            for (int s = 0; s < P_DEPTH; s++) begin
                id_q[s] <= '0;
            end
            for (int k = 0; k < P_REQS; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            ptr_q  <= ptr_d;
            pipe_q <= pipe_d;
            for (int s = 0; s < P_DEPTH; s++) begin
                id_q[s] <= id_d[s];
            end
            for (int k = 0; k < P_REQS; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign o_pipe_data = pipe_q;
    assign o_rsp_vld   = ret_hit;
    assign o_rsp_data  = i_pipe_data;
    assign o_busy      = |vld_q;

endmodule

// File: tb/tb_delay_line_arbiter.sv
// Bench for delay_line_arbiter: external line modelled as registers after o_pipe_data,
// transaction-level reference model (in-flight records with return cycle) checked every cycle.
module tb_delay_line_arbiter;

    localparam int P_REQS    = 4;
    localparam int P_DEPTH   = 8;
    localparam int P_WIDTH   = 8;
    localparam int P_MAX_OUT = 2;

    logic                      i_clk = 1'b0;
    logic                      i_rst = 1'b0;
    logic                      i_flush = 1'b0;
    logic [P_REQS-1:0]         i_req = '0;
    logic [P_REQS*P_WIDTH-1:0] i_data = '0;
    logic [P_REQS-1:0]         o_gnt;
    logic [P_WIDTH-1:0]        o_pipe_data;
    logic [P_WIDTH-1:0]        i_pipe_data;
    logic [P_REQS-1:0]         o_rsp_vld;
    logic [P_WIDTH-1:0]        o_rsp_data;
    logic                      o_busy;

    int checks = 0;
    int failures = 0;

    delay_line_arbiter #(
        .P_REQS(P_REQS), .P_DEPTH(P_DEPTH), .P_WIDTH(P_WIDTH), .P_MAX_OUT(P_MAX_OUT)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_req(i_req), .i_data(i_data),
        .o_gnt(o_gnt), .o_pipe_data(o_pipe_data), .i_pipe_data(i_pipe_data),
        .o_rsp_vld(o_rsp_vld), .o_rsp_data(o_rsp_data), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // o_pipe_data is the first stage of the line, so P_DEPTH-1 more registers follow it.
    logic [P_WIDTH-1:0] line_q [P_DEPTH-1];
    always @(posedge i_clk) begin
        line_q[0] <= o_pipe_data;
        for (int s = 1; s < P_DEPTH-1; s++) line_q[s] <= line_q[s-1];
    end
    assign i_pipe_data = line_q[P_DEPTH-2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: a word granted in cycle c returns in cycle c+P_DEPTH.
    typedef struct {
        int                 owner;
        logic [P_WIDTH-1:0] data;
        int                 ret;
    } rec_t;

    rec_t               inflight[$];
    int                 m_cnt [P_REQS];
    int                 m_ptr = 0;
    int                 m_cyc = 0;
    logic [P_WIDTH-1:0] m_last = '0;

    always @(negedge i_clk) begin
        logic [P_REQS-1:0]  exp_gnt, exp_rsp;
        logic [P_WIDTH-1:0] exp_rdat;
        int                 ret_pos, gk;
        if (!i_rst) begin
            check("rst_gnt", 32'(o_gnt), 0);
            check("rst_rsp", 32'(o_rsp_vld), 0);
            check("rst_busy", 32'(o_busy), 0);
            check("rst_pipe", 32'(o_pipe_data), 0);
            inflight.delete();
            for (int k = 0; k < P_REQS; k++) m_cnt[k] = 0;
            m_ptr = 0;
            m_last = '0;
        end else begin
            exp_rsp = '0;
            exp_rdat = '0;
            ret_pos = -1;
            for (int n = 0; n < inflight.size(); n++)
                if (inflight[n].ret == m_cyc) ret_pos = n;
            if (ret_pos >= 0 && !i_flush) begin
                exp_rsp[inflight[ret_pos].owner] = 1'b1;
                exp_rdat = inflight[ret_pos].data;
            end
            exp_gnt = '0;
            gk = -1;
            if (!i_flush) begin
                for (int i = 0; i < P_REQS; i++) begin
                    int k;
                    k = (m_ptr + i) % P_REQS;
                    if (gk < 0 && i_req[k] && (m_cnt[k] < P_MAX_OUT || exp_rsp[k])) gk = k;
                end
            end
            if (gk >= 0) exp_gnt[gk] = 1'b1;

            check("gnt", 32'(o_gnt), 32'(exp_gnt));
            check("rsp_vld", 32'(o_rsp_vld), 32'(exp_rsp));
            if (exp_rsp != 0) check("rsp_data", 32'(o_rsp_data), 32'(exp_rdat));
            check("busy", 32'(o_busy), 32'(inflight.size() != 0));
            check("pipe_data", 32'(o_pipe_data), 32'(m_last));

            if (i_flush) begin
                inflight.delete();
                for (int k = 0; k < P_REQS; k++) m_cnt[k] = 0;
            end else begin
                if (ret_pos >= 0) begin
                    m_cnt[inflight[ret_pos].owner]--;
                    inflight.delete(ret_pos);
                end
                if (gk >= 0) begin
                    rec_t r;
                    r.owner = gk;
                    r.data  = i_data[gk*P_WIDTH +: P_WIDTH];
                    r.ret   = m_cyc + P_DEPTH;
                    inflight.push_back(r);
                    m_cnt[gk]++;
                    m_ptr = (gk + 1) % P_REQS;
                    m_last = r.data;
                end
            end
        end
        m_cyc++;
    end

    task automatic next_cycle();
        @(posedge i_clk);
        #2;
    endtask

    task automatic sample();
        @(negedge i_clk);
    endtask

    task automatic idle(input int n);
        i_req = '0;
        repeat (n) next_cycle();
    endtask

    task automatic do_reset();
        next_cycle();
        i_rst = 1'b0;
        i_req = '0;
        i_flush = 1'b0;
        next_cycle();
        i_rst = 1'b1;
    endtask

    initial begin
        logic [P_REQS-1:0] exp_v;
        for (int k = 0; k < P_REQS; k++) m_cnt[k] = 0;
        repeat (2) next_cycle();
        i_rst = 1'b1;
        idle(2);

        // 1: single requester, fixed latency
        i_req = 4'b0001;
        i_data[7:0] = 8'h11;
        sample();
        check("t1_gnt", 32'(o_gnt), 32'h1);
        next_cycle();
        i_req = '0;
        repeat (7) next_cycle();
        sample();
        check("t1_rsp_vld", 32'(o_rsp_vld), 32'h1);
        check("t1_rsp_data", 32'(o_rsp_data), 32'h11);
        $display("t1 single req0 done");
        idle(10);

        // 2: all requesting, round-robin one per cycle
        do_reset();
        i_req = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            i_data = $urandom;
            sample();
            if (i < 5) begin
                exp_v = 4'(1 << (i % 4));
                check("t2_gnt", 32'(o_gnt), 32'(exp_v));
            end
            next_cycle();
        end
        $display("t2 all-request rotation done");
        idle(12);

        // 3: single requester hits its in-flight limit
        do_reset();
        i_req = 4'b0100;
        for (int i = 0; i < 9; i++) begin
            i_data = $urandom;
            sample();
            exp_v = (i < 2 || i == 8) ? 4'b0100 : 4'b0000;
            check("t3_gnt", 32'(o_gnt), 32'(exp_v));
            if (i == 8) check("t3_rsp", 32'(o_rsp_vld), 32'h4);
            next_cycle();
        end
        $display("t3 in-flight limit done");
        idle(12);

        // 4: flush discards in-flight words
        do_reset();
        i_req = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            i_data = $urandom;
            sample();
            exp_v = (i % 2 == 0) ? 4'b0010 : 4'b1000;
            check("t4_gnt", 32'(o_gnt), 32'(exp_v));
            next_cycle();
        end
        i_flush = 1'b1;
        sample();
        check("t4_flush_gnt", 32'(o_gnt), 0);
        next_cycle();
        i_flush = 1'b0;
        i_req = 4'b0010;
        sample();
        check("t4_busy", 32'(o_busy), 0);
        check("t4_regnt", 32'(o_gnt), 32'h2);
        next_cycle();
        $display("t4 flush done");
        idle(14);

        // 5: asynchronous reset with words in flight
        do_reset();
        i_req = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            i_data = $urandom;
            next_cycle();
        end
        i_rst = 1'b0;
        i_req = '0;
        #1;
        check("t5_rst_gnt", 32'(o_gnt), 0);
        check("t5_rst_busy", 32'(o_busy), 0);
        check("t5_rst_pipe", 32'(o_pipe_data), 0);
        next_cycle();
        i_rst = 1'b1;
        idle(12);
        i_req = 4'b0001;
        i_data[7:0] = 8'h5A;
        sample();
        check("t5_gnt", 32'(o_gnt), 32'h1);
        next_cycle();
        i_req = '0;
        repeat (7) next_cycle();
        sample();
        check("t5_rsp_vld", 32'(o_rsp_vld), 32'h1);
        check("t5_rsp_data", 32'(o_rsp_data), 32'h5A);
        $display("t5 async reset done");
        idle(10);

        // 6: wrap-around from pointer 3
        do_reset();
        i_req = 4'b0100;
        next_cycle();
        i_req = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            i_data = $urandom;
            sample();
            exp_v = (i % 2 == 0) ? 4'b1000 : 4'b0001;
            check("t6_gnt", 32'(o_gnt), 32'(exp_v));
            next_cycle();
        end
        $display("t6 wrap-around done");
        idle(12);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            i_req   = 4'($urandom_range(0, 15));
            i_data  = $urandom;
            i_flush = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 499) == 0) begin
                i_rst = 1'b0;
                next_cycle();
                i_rst = 1'b1;
            end
            next_cycle();
        end
        i_flush = 1'b0;
        $display("random phase done");
        idle(12);
        sample();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
